bp_me_cache_dma_to_bedrock: RTL

- Sits directly downstream of the L2 cache slice's DMA side.
- Consumes the slice's split outbound streams (mem_cmd header plus dword-wide data beats) and packs them into a single full-block BedRock cce mem message for the memory/NoC side.
- Unpacks full-block BedRock responses back into the slice's split header and dword-beat streams.
- Command path and response path are independent FSMs; each holds at most one message.

---
 rtl/bp_me_cache_dma_to_bedrock.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bp_me_cache_dma_to_bedrock.sv
// Bridges the L2 slice's split DMA streams (header + dword beats) to full-block
// BedRock mem messages, and splits full-block responses back into header + beats.
module bp_me_cache_dma_to_bedrock #(
    parameter int paddr_width_p     = 40,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int lce_assoc_p       = 8,
    parameter int data_width_p      = 64,
    localparam int way_id_width_lp  = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    // Header layout, LSB first: msg_type[4], subop[4], addr, size[3], lce_id, way_id
    localparam int cce_mem_msg_header_width_lp =
        4 + 4 + paddr_width_p + 3 + lce_id_width_p + way_id_width_lp,
    localparam int cce_mem_msg_width_lp = cce_mem_msg_header_width_lp + cce_block_width_p,
    localparam int beats_lp = cce_block_width_p / data_width_p
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic [cce_mem_msg_header_width_lp-1:0] dma_cmd_header_i,
    input  logic                                   dma_cmd_header_v_i,
    output logic                                   dma_cmd_header_yumi_o,
    input  logic [data_width_p-1:0]                dma_cmd_data_i,
    input  logic                                   dma_cmd_data_v_i,
    output logic                                   dma_cmd_data_yumi_o,

    output logic [cce_mem_msg_header_width_lp-1:0] dma_resp_header_o,
    output logic                                   dma_resp_header_v_o,
    input  logic                                   dma_resp_header_ready_i,
    output logic [data_width_p-1:0]                dma_resp_data_o,
    output logic                                   dma_resp_data_v_o,
    input  logic                                   dma_resp_data_ready_i,

    output logic [cce_mem_msg_width_lp-1:0]        mem_cmd_o,
    output logic                                   mem_cmd_v_o,
    input  logic                                   mem_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0]        mem_resp_i,
    input  logic                                   mem_resp_v_i,
    output logic                                   mem_resp_yumi_o
);

    localparam int hdr_w_lp = cce_mem_msg_header_width_lp;
    localparam int cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bedrock_mem_type_e;

    typedef enum logic [1:0] {e_ready, e_data, e_send} cmd_state_e;
    typedef enum logic {e_resp_ready, e_resp_stream} resp_state_e;

    // ---------------------------------------------------------------- cmd path
    cmd_state_e                 cmd_state_reg;
    logic [hdr_w_lp-1:0]        cmd_header_reg;
    logic [cnt_w_lp-1:0]        cmd_cnt_reg;
    logic [data_width_p-1:0]    cmd_beat_reg [beats_lp];
    logic                       cmd_is_wr;
    logic                       cmd_hdr_take;
    logic                       cmd_beat_take;

    assign cmd_is_wr = (dma_cmd_header_i[3:0] == e_bedrock_mem_wr)
                    || (dma_cmd_header_i[3:0] == e_bedrock_mem_uc_wr);

    // Handshakes are gated by reset so nothing is consumed while the block is held.
    assign cmd_hdr_take  = ~reset_i & (cmd_state_reg == e_ready) & dma_cmd_header_v_i;
    assign cmd_beat_take = ~reset_i & (cmd_state_reg == e_data)  & dma_cmd_data_v_i;

    assign dma_cmd_header_yumi_o = cmd_hdr_take;
    assign dma_cmd_data_yumi_o   = cmd_beat_take;
    assign mem_cmd_v_o           = (cmd_state_reg == e_send);
    assign mem_cmd_o[hdr_w_lp-1:0] = cmd_header_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cmd_state_reg  <= e_ready;
            cmd_header_reg <= '0;
            cmd_cnt_reg    <= '0;
        end else begin
            case (cmd_state_reg)
                e_ready: begin
                    if (cmd_hdr_take) begin
                        cmd_header_reg <= dma_cmd_header_i;
                        cmd_cnt_reg    <= '0;
                        cmd_state_reg  <= cmd_is_wr ? e_data : e_send;
                    end
                end
                e_data: begin
                    if (cmd_beat_take) begin
                        if (cmd_cnt_reg == last_beat_lp) begin
                            cmd_cnt_reg   <= '0;
                            cmd_state_reg <= e_send;
                        end else begin
                            cmd_cnt_reg <= cmd_cnt_reg + 1'b1;
                        end
                    end
                end
                e_send: begin
                    if (mem_cmd_ready_i) begin
                        cmd_state_reg <= e_ready;
                    end
                end
                default: cmd_state_reg <= e_ready;
            endcase
        end
    end

    // Each beat slot owns its register; slots clear on every new header so reads carry zero data.
    for (genvar gi = 0; gi < beats_lp; gi++) begin : g_cmd_beat
        always_ff @(posedge clk_i) begin
            if (reset_i || cmd_hdr_take) begin
                cmd_beat_reg[gi] <= '0;
            end else if (cmd_beat_take && (cmd_cnt_reg == cnt_w_lp'(gi))) begin
                cmd_beat_reg[gi] <= dma_cmd_data_i;
            end
        end
        assign mem_cmd_o[hdr_w_lp + gi*data_width_p +: data_width_p] = cmd_beat_reg[gi];
    end

    // --------------------------------------------------------------- resp path
    resp_state_e                  resp_state_reg;
    logic [cce_mem_msg_width_lp-1:0] resp_msg_reg;
    logic                         hdr_pend_reg;
    logic                         dat_pend_reg;
    logic [cnt_w_lp-1:0]          rcnt_reg;
    logic [data_width_p-1:0]      resp_beat [beats_lp];
    logic                         resp_is_wr;
    logic                         resp_take;
    logic                         hdr_hs;
    logic                         dat_hs;
    logic                         hdr_pend_next;
    logic                         dat_pend_next;

    assign resp_is_wr = (mem_resp_i[3:0] == e_bedrock_mem_wr)
                     || (mem_resp_i[3:0] == e_bedrock_mem_uc_wr);
    assign resp_take  = ~reset_i & (resp_state_reg == e_resp_ready) & mem_resp_v_i;

    assign mem_resp_yumi_o     = resp_take;
    assign dma_resp_header_o   = resp_msg_reg[hdr_w_lp-1:0];
    assign dma_resp_header_v_o = hdr_pend_reg;
    assign dma_resp_data_v_o   = dat_pend_reg;
    assign dma_resp_data_o     = resp_beat[rcnt_reg];

    for (genvar gi = 0; gi < beats_lp; gi++) begin : g_resp_beat
        assign resp_beat[gi] = resp_msg_reg[hdr_w_lp + gi*data_width_p +: data_width_p];
    end

    // Header and data channels retire independently; the message is done when both are.
    always_comb begin
        hdr_hs        = hdr_pend_reg & dma_resp_header_ready_i;
        dat_hs        = dat_pend_reg & dma_resp_data_ready_i;
        hdr_pend_next = hdr_pend_reg & ~hdr_hs;
        dat_pend_next = dat_pend_reg & ~(dat_hs & (rcnt_reg == last_beat_lp));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_state_reg <= e_resp_ready;
            resp_msg_reg   <= '0;
            hdr_pend_reg   <= 1'b0;
            dat_pend_reg   <= 1'b0;
            rcnt_reg       <= '0;
        end else begin
            case (resp_state_reg)
                e_resp_ready: begin
                    if (resp_take) begin
                        resp_msg_reg   <= mem_resp_i;
                        hdr_pend_reg   <= 1'b1;
                        dat_pend_reg   <= ~resp_is_wr;
                        rcnt_reg       <= '0;
                        resp_state_reg <= e_resp_stream;
                    end
                end
                e_resp_stream: begin
                    hdr_pend_reg <= hdr_pend_next;
                    dat_pend_reg <= dat_pend_next;
                    if (dat_hs) begin
                        rcnt_reg <= (rcnt_reg == last_beat_lp) ? '0 : rcnt_reg + 1'b1;
                    end
                    if (!hdr_pend_next && !dat_pend_next) begin
                        resp_state_reg <= e_resp_ready;
                    end
                end
                default: resp_state_reg <= e_resp_ready;
            endcase
        end
    end

endmodule
